// File: rtl/add64_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit adder slice is reused over WIDTH/SLICE
// cycles with the carry chained through a register. Valid/ready on both sides.
module add64_slice_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  // Handshake rule (both sides): a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on ready.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             cout_q, cout_d, v_q, v_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   sum_sl;
  logic             msb_cin;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;

  always_comb begin
    a_sl    = a_q[int'(idx_q)*SLICE +: SLICE];
    b_sl    = b_q[int'(idx_q)*SLICE +: SLICE];
    sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the MSB sum bit; also holds for SLICE=1.
    msb_cin = sum_sl[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];

    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[int'(idx_q)*SLICE +: SLICE] = sum_sl[SLICE-1:0];
        carry_d = sum_sl[SLICE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = sum_sl[SLICE];
          v_d     = sum_sl[SLICE] ^ msb_cin;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

endmodule
